// File: rtl/mic_pkg.sv
// Shared definitions for the microprogram sequencer: widths, MIR field layout,
// memory-operation encodings and the sequencer state enum.
package mic_pkg;

    localparam int unsigned CsWidth   = 36;
    localparam int unsigned AddrWidth = 9;
    localparam int unsigned MbrWidth  = 8;

    localparam int unsigned NextAddrMsb = 35;
    localparam int unsigned NextAddrLsb = 27;
    localparam int unsigned JmpcBit     = 26;
    localparam int unsigned JamnBit     = 25;
    localparam int unsigned JamzBit     = 24;
    localparam int unsigned MemMsb      = 5;
    localparam int unsigned MemLsb      = 4;

    typedef enum logic [1:0] {
        MemNone  = 2'b00,
        MemRead  = 2'b01,
        MemWrite = 2'b10,
        MemFetch = 2'b11
    } mem_op_e;

    typedef enum logic [2:0] {
        StIFetch,
        StDecode,
        StExec,
        StMemW,
        StNext,
        StHalt
    } state_e;

endpackage

// File: rtl/mic_next_addr.sv
// Next microaddress: OR-only, no carries. JMPC merges MBR into the low byte and
// overrides the JAMN/JAMZ conditional set of the top bit.
module mic_next_addr
    import mic_pkg::*;
(
    input  logic [AddrWidth-1:0] next_addr,
    input  logic                 jmpc,
    input  logic                 jamn,
    input  logic                 jamz,
    input  logic                 n,
    input  logic                 z,
    input  logic [MbrWidth-1:0]  mbr,
    output logic [AddrWidth-1:0] mpc_next
);

    always_comb begin
        mpc_next = next_addr;
        if (jmpc) begin
            mpc_next[MbrWidth-1:0] = next_addr[MbrWidth-1:0] | mbr;
        end else begin
            mpc_next[AddrWidth-1] = next_addr[AddrWidth-1] | (jamn & n) | (jamz & z);
        end
    end

endmodule

// File: rtl/mic_sequencer.sv
// Microprogram sequencer: fetches a 36-bit microinstruction, strobes the datapath,
// optionally waits on a memory handshake, then branches. Stops for good at HALT_ADDR.
module mic_sequencer
    import mic_pkg::*;
#(
    parameter logic [AddrWidth-1:0] MPC_RESET = 9'h000,
    parameter logic [AddrWidth-1:0] HALT_ADDR = 9'h1FF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 run,
    output logic [AddrWidth-1:0] cs_addr,
    input  logic [CsWidth-1:0]   cs_data,
    output logic [CsWidth-1:0]   mir,
    input  logic [MbrWidth-1:0]  mbr,
    input  logic                 alu_n,
    input  logic                 alu_z,
    output logic                 dp_en,
    output logic                 mem_req,
    output logic [1:0]           mem_op,
    input  logic                 mem_ack,
    output logic                 halted
);

    state_e               state_q;
    logic [AddrWidth-1:0] mpc_q;
    logic [CsWidth-1:0]   mir_q;
    logic                 n_q;
    logic                 z_q;
    logic                 dp_en_q;
    logic                 mem_req_q;
    logic [1:0]           mem_op_q;
    logic                 halted_q;

    logic [AddrWidth-1:0] f_next_addr;
    logic                 f_jmpc;
    logic                 f_jamn;
    logic                 f_jamz;
    logic [1:0]           f_mem;
    logic [AddrWidth-1:0] mpc_next;

    assign f_next_addr = mir_q[NextAddrMsb:NextAddrLsb];
    assign f_jmpc      = mir_q[JmpcBit];
    assign f_jamn      = mir_q[JamnBit];
    assign f_jamz      = mir_q[JamzBit];
    assign f_mem       = mir_q[MemMsb:MemLsb];

    mic_next_addr u_next_addr (
        .next_addr (f_next_addr),
        .jmpc      (f_jmpc),
        .jamn      (f_jamn),
        .jamz      (f_jamz),
        .n         (n_q),
        .z         (z_q),
        .mbr       (mbr),
        .mpc_next  (mpc_next)
    );

    // Outputs are registered: each is set on the edge entering the state that owns it.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIFetch;
            mpc_q     <= MPC_RESET;
            mir_q     <= '0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
            dp_en_q   <= 1'b0;
            mem_req_q <= 1'b0;
            mem_op_q  <= MemNone;
            halted_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIFetch: begin
                    if (run) begin
                        state_q <= StDecode;
                    end
                end
                StDecode: begin
                    mir_q   <= cs_data;
                    dp_en_q <= 1'b1;
                    state_q <= StExec;
                end
                StExec: begin
                    dp_en_q <= 1'b0;
                    n_q     <= alu_n;
                    z_q     <= alu_z;
                    if (f_mem != MemNone) begin
                        mem_req_q <= 1'b1;
                        mem_op_q  <= f_mem;
                        state_q   <= StMemW;
                    end else begin
                        state_q <= StNext;
                    end
                end
                StMemW: begin
                    if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_op_q  <= MemNone;
                        state_q   <= StNext;
                    end
                end
                StNext: begin
                    mpc_q <= mpc_next;
                    if (mpc_next == HALT_ADDR) begin
                        halted_q <= 1'b1;
                        state_q  <= StHalt;
                    end else begin
                        state_q <= StIFetch;
                    end
                end
                StHalt: begin
                    state_q <= StHalt;
                end
                default: begin
                    state_q <= StIFetch;
                end
            endcase
        end
    end

    assign cs_addr = mpc_q;
    assign mir     = mir_q;
    assign dp_en   = dp_en_q;
    assign mem_req = mem_req_q;
    assign mem_op  = mem_op_q;
    assign halted  = halted_q;

    // Strobe and request live in disjoint states, so they can never overlap.
    assert property (@(posedge clk) disable iff (rst) !(dp_en_q && mem_req_q));
    assert property (@(posedge clk) disable iff (rst) dp_en_q |=> !dp_en_q);
    assert property (@(posedge clk) disable iff (rst) halted_q |=> halted_q);

endmodule

// File: tb/tb_mic_sequencer.sv
// Randomized scoreboard bench for mic_sequencer: a trace model predicts every executed
// microinstruction; a monitor checks them as the DUT strobes dp_en.
module tb_mic_sequencer;
    import mic_pkg::*;

    localparam logic [8:0] MpcReset = 9'h000;
    localparam logic [8:0] HaltAddr = 9'h1FF;
    localparam int MaxInstr = 40;
    localparam int NumEpisodes = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [8:0]  cs_addr;
    logic [35:0] cs_data;
    logic [35:0] mir;
    logic [7:0]  mbr;
    logic        alu_n;
    logic        alu_z;
    logic        dp_en;
    logic        mem_req;
    logic [1:0]  mem_op;
    logic        mem_ack;
    logic        halted;

    always #5 clk = ~clk;

    mic_sequencer #(
        .MPC_RESET (MpcReset),
        .HALT_ADDR (HaltAddr)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .cs_addr (cs_addr),
        .cs_data (cs_data),
        .mir     (mir),
        .mbr     (mbr),
        .alu_n   (alu_n),
        .alu_z   (alu_z),
        .dp_en   (dp_en),
        .mem_req (mem_req),
        .mem_op  (mem_op),
        .mem_ack (mem_ack),
        .halted  (halted)
    );

    // Environment: control store, per-address flags/MBR, per-address memory latency.
    logic [35:0] rom     [512];
    bit          n_tab   [512];
    bit          z_tab   [512];
    logic [7:0]  mbr_tab [512];
    int          dly_tab [512];

    always @(posedge clk) cs_data <= rom[cs_addr];
    assign alu_n = n_tab[cs_addr];
    assign alu_z = z_tab[cs_addr];
    assign mbr   = mbr_tab[cs_addr];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic [35:0] word;
        logic [1:0]  mem;
        int          k;
        bit          halts;
    } rec_t;

    rec_t exp_q[$];

    function automatic logic [35:0] mk(input logic [8:0] na, input bit jmpc, input bit jamn,
                                       input bit jamz, input logic [1:0] mem);
        logic [17:0] fill_hi = 18'($urandom);
        logic [3:0]  fill_lo = 4'($urandom);
        return {na, jmpc, jamn, jamz, fill_hi, mem, fill_lo};
    endfunction

    // Reference model: walk the microprogram with the branch rules as plain arithmetic.
    task automatic build_trace(output bit halts);
        logic [8:0] a = MpcReset;
        halts = 0;
        for (int i = 0; i < MaxInstr; i++) begin
            rec_t r;
            logic [35:0] w = rom[a];
            logic [8:0] na = w[35:27];
            logic [8:0] nxt;
            if (w[26]) nxt = {na[8], na[7:0] | mbr_tab[a]};
            else       nxt = na | (9'((w[25] & n_tab[a]) | (w[24] & z_tab[a])) << 8);
            r.addr  = a;
            r.word  = w;
            r.mem   = w[5:4];
            r.k     = (w[5:4] != 2'b00) ? dly_tab[a] : 0;
            r.halts = (nxt == HaltAddr);
            exp_q.push_back(r);
            if (r.halts) begin
                halts = 1;
                return;
            end
            a = nxt;
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < 512; i++) begin
            logic [8:0] na = ($urandom_range(15) == 0) ? HaltAddr : 9'($urandom);
            logic [1:0] mem = ($urandom_range(1) == 1) ? 2'($urandom) : 2'b00;
            rom[i]     = mk(na, $urandom_range(3) == 0, $urandom_range(2) == 0,
                            $urandom_range(2) == 0, mem);
            n_tab[i]   = 1'($urandom_range(1));
            z_tab[i]   = 1'($urandom_range(1));
            mbr_tab[i] = 8'($urandom);
            dly_tab[i] = $urandom_range(1, 4);
        end
    endtask

    // Hand-built path: 000 -> 005 -> (z ? 112 : 012) -> 136 -> 1FF.
    task automatic fill_directed(input bit z);
        fill_random();
        rom[9'h000] = mk(9'h005, 0, 0, 0, 2'b00);
        rom[9'h005] = mk(9'h012, 0, 0, 1, 2'b00);
        z_tab[9'h005] = z;
        rom[9'h012] = mk(9'h100, 1, 1, 0, 2'b00);
        n_tab[9'h012] = 1;
        mbr_tab[9'h012] = 8'h36;
        rom[9'h112] = mk(9'h100, 1, 1, 0, 2'b01);
        n_tab[9'h112] = 1;
        mbr_tab[9'h112] = 8'h36;
        dly_tab[9'h112] = 3;
        rom[9'h136] = mk(9'h1FF, 0, 0, 0, 2'b10);
        dly_tab[9'h136] = 2;
    endtask

    // Memory responder: ack after the per-address latency; stray acks when idle.
    int ack_cnt = 0;
    always @(negedge clk) begin
        if (mem_req) begin
            ack_cnt++;
            mem_ack = (ack_cnt == dly_tab[cs_addr]);
        end else begin
            ack_cnt = 0;
            mem_ack = ($urandom_range(3) == 0);
        end
    end

    // Monitor
    rec_t cur;
    bit   have_cur  = 0;
    bit   halt_seen = 0;
    bit   post_rst  = 0;
    int   gap       = 0;
    int   memcyc    = 0;

    always @(negedge clk) begin
        if (rst) begin
            have_cur  = 0;
            halt_seen = 0;
            post_rst  = 1;
            gap       = 0;
            memcyc    = 0;
        end else begin
            gap++;
            if (post_rst) begin
                post_rst = 0;
                chk("reset_outputs", {dp_en, mem_req, mem_op, halted, cs_addr, mir},
                    {1'b0, 1'b0, 2'b00, 1'b0, MpcReset, 36'h0});
            end
            if (dp_en || mem_req) chk("strobe_exclusive", dp_en & mem_req, 0);
            if (dp_en) begin
                if (have_cur) begin
                    chk("latency", gap, 4 + cur.k);
                    chk("mem_cycles", memcyc, cur.k);
                end else begin
                    chk("first_exec_cycle", gap, 3);
                end
                chk("exec_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur = exp_q.pop_front();
                    have_cur = 1;
                    chk("exec_addr", cs_addr, cur.addr);
                    chk("mir", mir, cur.word);
                end
                gap    = 0;
                memcyc = 0;
            end
            if (mem_req) begin
                memcyc++;
                if (have_cur) chk("mem_op", mem_op, cur.mem);
            end
            if (halted && !halt_seen) begin
                halt_seen = 1;
                chk("halt_expected", have_cur && cur.halts, 1);
                chk("halt_latency", gap, cur.k + 2);
                chk("halt_mem_cycles", memcyc, cur.k);
            end
            if (halt_seen) chk("halt_hold", {halted, dp_en, mem_req, cs_addr},
                               {1'b1, 1'b0, 1'b0, HaltAddr});
        end
    end

    // Runs until the trace is consumed; optionally resets in the 2nd MEMW cycle.
    task automatic run_episode(input bit halts, input bit mem_reset);
        int  cyc = 0;
        bit  prev_req = 0;
        bit  aborted = 0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (mem_reset && mem_req && prev_req) begin
                aborted = 1;
                break;
            end
            prev_req = mem_req;
            if (exp_q.size() == 0) break;
            if (cyc > 2000) begin
                chk("episode_timeout", exp_q.size(), 0);
                aborted = 1;
                break;
            end
        end
        if (halts && !aborted) begin
            int w = 0;
            while (!halted && w < 10) begin
                @(posedge clk);
                #1;
                w++;
            end
            chk("halt_reached", halted, 1);
            repeat (20) begin
                @(posedge clk);
                #1;
                run = 1'($urandom_range(1));
            end
            run = 1;
        end
    endtask

    initial begin
        bit halts;
        rst = 1;
        run = 1;
        for (int ep = 0; ep < NumEpisodes; ep++) begin
            @(posedge clk);
            #1;
            rst = 1;
            run = 1;
            exp_q.delete();
            if (ep < 2) fill_directed(ep == 1);
            else        fill_random();
            build_trace(halts);
            @(posedge clk);
            #1;
            rst = 0;
            run_episode(halts, (ep % 3) == 2);
        end
        @(posedge clk);
        #1;
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        errors++;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
